// File: rtl/simon_sequence_gen.sv
// Simon colour sequence generator: von Neumann debiased TRNG bits pair into 2-bit colours,
// appended to an on-chip store on request, with an LFSR fallback for a stuck source.
module simon_sequence_gen #(
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned SAMPLE_DIV  = 16,
  parameter int unsigned STUCK_LIMIT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       random_in_i,
  output logic                       osc_en_o,
  input  logic                       new_game_i,
  input  logic                       extend_i,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx_i,
  output logic [1:0]                 rd_color_o,
  output logic [$clog2(MAX_LEN):0]   seq_len_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       full_o,
  output logic                       stuck_o
);

  localparam int unsigned IdxW  = $clog2(MAX_LEN);
  localparam int unsigned CntW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned DiscW = $clog2(STUCK_LIMIT + 1);

  localparam logic [CntW-1:0]  SampleLast = CntW'(SAMPLE_DIV - 1);
  localparam logic [DiscW-1:0] DiscLimit  = DiscW'(STUCK_LIMIT);
  localparam logic [IdxW:0]    LenMax     = (IdxW + 1)'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StHarvest, StStore} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  samp_cnt_q, samp_cnt_d;
  logic             have_a_q, have_a_d;
  logic             a_q, a_d;
  logic             got_first_q, got_first_d;
  logic [1:0]       color_q, color_d;
  logic [DiscW-1:0] disc_q, disc_d;
  logic [IdxW:0]    seq_len_q, seq_len_d;
  logic             stuck_q, stuck_d;
  logic             done_q, done_d;
  logic [1:0]       rd_color_q, rd_color_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [1:0]       mem_q [MAX_LEN];
  logic             mem_we;
  logic             take_bit;
  logic             bit_val;

  // Fibonacci x^8+x^6+x^5+x^4+1; free-running so the fallback bits keep changing.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  assign rd_color_d = ({1'b0, rd_idx_i} < seq_len_q) ? mem_q[rd_idx_i] : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      samp_cnt_q  <= '0;
      have_a_q    <= 1'b0;
      a_q         <= 1'b0;
      got_first_q <= 1'b0;
      color_q     <= 2'b00;
      disc_q      <= '0;
      seq_len_q   <= '0;
      stuck_q     <= 1'b0;
      done_q      <= 1'b0;
      rd_color_q  <= 2'b00;
      lfsr_q      <= 8'hA5;
    end else begin
      state_q     <= state_d;
      samp_cnt_q  <= samp_cnt_d;
      have_a_q    <= have_a_d;
      a_q         <= a_d;
      got_first_q <= got_first_d;
      color_q     <= color_d;
      disc_q      <= disc_d;
      seq_len_q   <= seq_len_d;
      stuck_q     <= stuck_d;
      done_q      <= done_d;
      rd_color_q  <= rd_color_d;
      lfsr_q      <= lfsr_d;
    end
  end

  // Storage array is deliberately not reset; seq_len gates every read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[seq_len_q[IdxW-1:0]] <= color_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    have_a_d    = have_a_q;
    a_d         = a_q;
    got_first_d = got_first_q;
    color_d     = color_q;
    disc_d      = disc_q;
    seq_len_d   = seq_len_q;
    stuck_d     = stuck_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    take_bit    = 1'b0;
    bit_val     = 1'b0;

    if (new_game_i) begin
      state_d     = StIdle;
      seq_len_d   = '0;
      stuck_d     = 1'b0;
      samp_cnt_d  = '0;
      have_a_d    = 1'b0;
      got_first_d = 1'b0;
      disc_d      = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (extend_i && !full_o && !busy_o) begin
            state_d     = StHarvest;
            samp_cnt_d  = '0;
            have_a_d    = 1'b0;
            got_first_d = 1'b0;
            disc_d      = '0;
            color_d     = 2'b00;
          end
        end
        StHarvest: begin
          if (disc_q == DiscLimit) begin
            take_bit = 1'b1;
            bit_val  = lfsr_q[0];
          end else begin
            samp_cnt_d = (samp_cnt_q == SampleLast) ? '0 : samp_cnt_q + CntW'(1);
            if (samp_cnt_q == SampleLast) begin
              if (!have_a_q) begin
                have_a_d = 1'b1;
                a_d      = random_in_i;
              end else begin
                have_a_d = 1'b0;
                if (a_q != random_in_i) begin
                  take_bit = 1'b1;
                  bit_val  = a_q;
                end else begin
                  disc_d = disc_q + DiscW'(1);
                  if (disc_d == DiscLimit) begin
                    stuck_d = 1'b1;
                  end
                end
              end
            end
          end
          if (take_bit) begin
            color_d     = {color_q[0], bit_val};
            got_first_d = 1'b1;
            if (got_first_q) begin
              state_d = StStore;
            end
          end
        end
        StStore: begin
          mem_we    = 1'b1;
          seq_len_d = seq_len_q + (IdxW + 1)'(1);
          done_d    = 1'b1;
          state_d   = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // busy covers the done cycle so a request coinciding with done is dropped.
  always_comb begin
    osc_en_o   = (state_q == StHarvest);
    busy_o     = (state_q != StIdle) || done_q;
    done_o     = done_q;
    full_o     = (seq_len_q == LenMax);
    stuck_o    = stuck_q;
    seq_len_o  = seq_len_q;
    rd_color_o = rd_color_q;
  end

endmodule

// File: tb/tb_simon_sequence_gen.sv
// Randomized bench for simon_sequence_gen against a sample-level reference model.
module tb_simon_sequence_gen;

  localparam int unsigned MaxLen     = 4;
  localparam int unsigned SampleDiv  = 4;
  localparam int unsigned StuckLimit = 4;
  localparam int unsigned IdxW       = $clog2(MaxLen);
  localparam int          MaxCyc     = 20000;

  logic            clk;
  logic            reset;
  logic            random_in;
  logic            osc_en;
  logic            new_game;
  logic            extend;
  logic [IdxW-1:0] rd_idx;
  logic [1:0]      rd_color;
  logic [IdxW:0]   seq_len;
  logic            busy;
  logic            done;
  logic            full;
  logic            stuck;

  simon_sequence_gen #(
    .MAX_LEN    (MaxLen),
    .SAMPLE_DIV (SampleDiv),
    .STUCK_LIMIT(StuckLimit)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .random_in_i(random_in),
    .osc_en_o   (osc_en),
    .new_game_i (new_game),
    .extend_i   (extend),
    .rd_idx_i   (rd_idx),
    .rd_color_o (rd_color),
    .seq_len_o  (seq_len),
    .busy_o     (busy),
    .done_o     (done),
    .full_o     (full),
    .stuck_o    (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks;
  int         n_errors;
  int         cyc;
  int         e_edge;
  int         mode;
  bit         rin [MaxCyc];
  bit         lb  [MaxCyc];
  logic [7:0] lfsr_m;
  bit         script [$];
  logic [1:0] exp_mem [MaxLen];
  int         exp_len;
  bit         exp_stuck;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Source modes: 0 fair coin, 1 stuck at 0, 2 scripted samples, 3 biased towards 1.
  function automatic bit next_rin();
    int idx;
    case (mode)
      1: return 1'b0;
      2: begin
        idx = (cyc - e_edge) / int'(SampleDiv);
        if (idx >= 0 && idx < script.size()) return script[idx];
        return bit'($urandom_range(0, 1));
      end
      3: return ($urandom_range(0, 9) < 8);
      default: return bit'($urandom_range(0, 1));
    endcase
  endfunction

  // Edge n is the n-th posedge since reset release; rin/lb hold what that edge sees.
  task automatic tick();
    if (cyc + 2 >= MaxCyc) begin
      $display("FAIL cycle_budget: got %0d cycles required below %0d", cyc, MaxCyc);
      $fatal(1);
    end
    random_in   = next_rin();
    rin[cyc+1]  = random_in;
    lb[cyc+1]   = lfsr_m[0];
    @(posedge clk);
    cyc++;
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    @(negedge clk);
  endtask

  // Walks the sample stream a pair at a time from the edge that accepted extend.
  task automatic predict(input int e, output int d, output logic [1:0] c, output bit fb);
    int t;
    int nb;
    int disc;
    bit a;
    bit b;
    t = e; nb = 0; disc = 0; c = 2'b00; fb = 1'b0;
    while (nb < 2) begin
      if (disc == int'(StuckLimit)) begin
        t++;
        c  = {c[0], lb[t]};
        nb++;
        fb = 1'b1;
      end else begin
        a = rin[t + int'(SampleDiv)];
        b = rin[t + 2 * int'(SampleDiv)];
        t = t + 2 * int'(SampleDiv);
        if (a != b) begin
          c = {c[0], a};
          nb++;
        end else begin
          disc++;
        end
      end
    end
    d = t + 1;
  endtask

  task automatic check_read(input int idx);
    logic [1:0] exp;
    rd_idx = IdxW'(idx);
    tick();
    exp = (idx < exp_len) ? exp_mem[idx] : 2'b00;
    check_val("rd_color", rd_color, exp);
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick();
    new_game  = 1'b0;
    exp_len   = 0;
    exp_stuck = 1'b0;
    check_val("ng_seq_len", seq_len, 0);
    check_val("ng_stuck", stuck, 0);
    check_val("ng_busy", busy, 0);
    check_val("ng_full", full, 0);
  endtask

  task automatic run_extend(input int m, input bit poke, input bit b2b);
    int         e;
    int         d;
    int         limit;
    logic [1:0] c;
    bit         fb;
    bit         seen;
    mode   = m;
    e_edge = cyc + 1;
    e      = cyc + 1;
    extend = 1'b1;
    tick();
    extend = 1'b0;
    check_val("busy_rise", busy, 1);
    check_val("osc_rise", osc_en, 1);
    limit = (2 * int'(StuckLimit) + 4) * int'(SampleDiv) + 4;
    seen  = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      extend = poke && (k == 2);
      tick();
      extend = 1'b0;
      seen   = done;
    end
    check_val("done_seen", seen, 1);
    predict(e, d, c, fb);
    if (seen) begin
      check_val("done_latency", cyc - e, d - e);
      check_val("busy_in_done", busy, 1);
      check_val("osc_after_done", osc_en, 0);
      exp_mem[exp_len] = c;
      exp_len++;
      exp_stuck |= fb;
      check_val("seq_len", seq_len, exp_len);
      check_val("stuck", stuck, exp_stuck);
    end
    extend = b2b;
    tick();
    extend = 1'b0;
    check_val("done_pulse", done, 0);
    check_val(b2b ? "b2b_ignored" : "idle_busy", busy, 0);
    if (exp_len > 0) check_read(exp_len - 1);
  endtask

  task automatic wait_no_done(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      seen |= done;
    end
    check_val(tag, seen, 0);
  endtask

  initial begin
    int r;
    n_checks = 0; n_errors = 0; cyc = 0; e_edge = 0; mode = 0;
    reset = 1'b0; random_in = 1'b0; new_game = 1'b0; extend = 1'b0; rd_idx = '0;
    exp_len = 0; exp_stuck = 1'b0; lfsr_m = 8'hA5;
    repeat (3) @(negedge clk);
    check_val("rst_osc_en", osc_en, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_full", full, 0);
    check_val("rst_stuck", stuck, 0);
    check_val("rst_seq_len", seq_len, 0);
    check_val("rst_rd_color", rd_color, 0);
    reset = 1'b1;

    // Von Neumann path: 01 then 10 -> colour 01.
    script = '{1'b0, 1'b1, 1'b1, 1'b0};
    run_extend(2, 1'b0, 1'b0);
    check_read(0);
    // Two discarded pairs then 10, 10 -> colour 11.
    script = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    run_extend(2, 1'b0, 1'b1);
    // Stuck source forces the LFSR fallback.
    run_extend(1, 1'b0, 1'b0);
    do_new_game();
    check_read(0);

    // new_game beats extend in the same cycle.
    new_game = 1'b1; extend = 1'b1;
    tick();
    new_game = 1'b0; extend = 1'b0;
    check_val("coll_busy", busy, 0);
    check_val("coll_osc", osc_en, 0);
    check_val("coll_seq_len", seq_len, 0);
    wait_no_done("coll_no_done", 4 * int'(SampleDiv) + 4);

    // extend while busy is ignored.
    run_extend(0, 1'b1, 1'b0);

    // new_game mid-harvest aborts with no write.
    mode = 0; extend = 1'b1;
    tick();
    extend = 1'b0;
    repeat (5) tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0; exp_len = 0; exp_stuck = 1'b0;
    check_val("abort_osc", osc_en, 0);
    check_val("abort_busy", busy, 0);
    wait_no_done("abort_no_done", 4 * int'(SampleDiv) + 4);
    check_val("abort_seq_len", seq_len, 0);

    // Fill to capacity; the extra request is dropped.
    for (int i = 0; i < int'(MaxLen); i++) run_extend(0, 1'b0, (i == 1));
    extend = 1'b1;
    tick();
    extend = 1'b0;
    check_val("full_ignored", busy, 0);
    wait_no_done("full_no_done", 4 * int'(SampleDiv) + 4);
    check_val("full_seq_len", seq_len, MaxLen);
    check_val("full_flag", full, 1);
    for (int i = 0; i < int'(MaxLen); i++) check_read(i);
    do_new_game();
    check_read(MaxLen - 1);

    // Randomized mix of requests, restarts and reads.
    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(0, 9));
      if (exp_len == int'(MaxLen) || r == 0) do_new_game();
      else if (r < 3) check_read(int'($urandom_range(0, MaxLen - 1)));
      else run_extend((r < 6) ? 0 : ((r < 8) ? 3 : 1), (r == 5), (r % 2 == 1));
    end

    // Asynchronous reset in the middle of a harvest.
    if (exp_len == int'(MaxLen)) do_new_game();
    if (exp_len == 0) run_extend(0, 1'b0, 1'b0);
    mode = 0; extend = 1'b1;
    tick();
    extend = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    check_val("arst_osc", osc_en, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_seq_len", seq_len, 0);
    check_val("arst_rd_color", rd_color, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1; lfsr_m = 8'hA5; exp_len = 0; exp_stuck = 1'b0;
    run_extend(1, 1'b0, 1'b0);
    check_read(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
